// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch queue.
// No logic here; widths default to a 32-bit core.
// Imported by the fetch top and its FIFO.
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_W  = 32;
  localparam int unsigned FETCH_INSTR_W = 32;

  // Sequential fetch advances by one 32-bit instruction.
  localparam int unsigned PC_INC = 4;

  // Low PC bits forced to zero (word alignment).
  localparam int unsigned ALIGN_MASK = 3;

  // One queued fetch: the return address of the instruction plus its encoding.
  typedef struct packed {
    logic [FETCH_ADDR_W-1:0]  pcp4;
    logic [FETCH_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Purpose: synchronous DEPTH-entry FIFO with flush, combinational head read.
// Latency: a pushed entry is visible at the head on the following cycle.
// Backpressure: push ignored when full unless a pop frees a slot the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned W     = FETCH_ADDR_W + FETCH_INSTR_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop,
  output logic [W-1:0]               head_dat,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | pop);
  assign head_dat = mem[rd_ptr];

  // Storage write; no reset needed since the head is only trusted when not empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointer and occupancy tracking; flush drops every entry by catching rd up to wr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_queue_unit.sv
// Purpose: PC owner and prefetch buffer feeding decode with {pc+4, instr} pairs.
// Latency: fetch in cycle N shows at out_valid in N+1; redirect target appears 2 cycles later.
// Backpressure: out_ready low fills the queue; when full the PC holds and imem_data is ignored.
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = FETCH_ADDR_W,
  parameter int unsigned       INSTR_W  = FETCH_INSTR_W,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      fetch_en,
  output logic [ADDR_W-1:0]         imem_addr,
  input  logic [INSTR_W-1:0]        imem_data,
  input  logic                      redirect,
  input  logic [ADDR_W-1:0]         redirect_pc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [INSTR_W-1:0]        out_instr,
  output logic [ADDR_W-1:0]         out_pcp4,
  output logic [$clog2(DEPTH):0]    count
);

  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(PC_INC);
  localparam logic [ADDR_W-1:0] ALIGN_KEEP = ~ADDR_W'(ALIGN_MASK);

  typedef struct packed {
    logic [ADDR_W-1:0]  pcp4;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [ADDR_W-1:0] pc;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic              fifo_full;
  entry_t            wr_entry;
  entry_t            head_entry;

  assign imem_addr = pc;
  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;
  // Redirect wins over fetch; a slot freed by this cycle's pop may be refilled at once.
  assign push      = fetch_en & ~redirect & (~fifo_full | pop);
  assign wr_entry  = '{pcp4: pc + PC_STEP, instr: imem_data};

  // Head is zeroed when empty so decode never sees stale storage.
  assign out_instr = out_valid ? head_entry.instr : '0;
  assign out_pcp4  = out_valid ? head_entry.pcp4  : '0;

  // PC: redirect reloads the aligned target, otherwise advance only on an accepted fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC & ALIGN_KEEP;
    end else if (redirect) begin
      pc <= redirect_pc & ALIGN_KEEP;
    end else if (push) begin
      pc <= pc + PC_STEP;
    end
  end

  fetch_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect),
    .push     (push),
    .push_dat (wr_entry),
    .pop      (pop),
    .head_dat (head_entry),
    .count    (count),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit with a queue-based reference model.
// Instruction memory is modelled as data = address ^ KEY.
module tb_fetch_queue_unit;

  localparam int unsigned DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] KEY    = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pcp4;
  logic [2:0]  count;

  always #5 clk = ~clk;

  assign imem_data = imem_addr ^ KEY;

  fetch_queue_unit #(
    .ADDR_W   (32),
    .INSTR_W  (32),
    .DEPTH    (DEPTH),
    .RESET_PC (RST_PC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_en    (fetch_en),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pcp4    (out_pcp4),
    .count       (count)
  );

  typedef struct {
    logic [31:0] pcp4;
    logic [31:0] instr;
  } ment_t;

  ment_t       mq[$];
  logic [31:0] mpc;
  int          total  = 0;
  int          passed = 0;
  bit          chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Reference model: a plain queue of fetched pairs and a PC.
  always @(posedge clk or negedge rst_n) begin
    bit p_pop;
    bit p_push;
    if (!rst_n) begin
      mq.delete();
      mpc = RST_PC & ~32'h3;
    end else begin
      p_pop  = (mq.size() != 0) && out_ready;
      p_push = fetch_en && !redirect && ((mq.size() < DEPTH) || p_pop);
      if (redirect) begin
        mq.delete();
        mpc = redirect_pc & ~32'h3;
      end else begin
        if (p_pop) void'(mq.pop_front());
        if (p_push) begin
          mq.push_back('{pcp4: mpc + 32'd4, instr: mpc ^ KEY});
          mpc = mpc + 32'd4;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("imem_addr", imem_addr, mpc);
      chk("count", 32'(count), 32'(mq.size()));
      chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("out_pcp4", out_pcp4, mq[0].pcp4);
        chk("out_instr", out_instr, mq[0].instr);
      end else begin
        chk("out_pcp4_empty", out_pcp4, 32'h0);
        chk("out_instr_empty", out_instr, 32'h0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b1;
    fetch_en    = 1'b1;
    out_ready   = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_addr", imem_addr, 32'h0040_0000);
    chk("rst_pcp4", out_pcp4, 32'h0);
    chk("rst_instr", out_instr, 32'h0);
    chk_en = 1'b1;

    tick(); rst_n = 1'b1;
    tick();
    chk("first_valid", 32'(out_valid), 32'd1);
    chk("first_pcp4", out_pcp4, 32'h0040_0004);
    chk("first_instr", out_instr, 32'hA5E5_A5A5);
    tick();
    chk("second_pcp4", out_pcp4, 32'h0040_0008);

    // Decode stall: queue fills, PC freezes.
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 2) chk("sat_count", 32'(count), 32'd4);
    end
    chk("full_count", 32'(count), 32'd4);
    chk("frozen_pc", imem_addr, 32'h0040_0014);
    chk("full_head", out_pcp4, 32'h0040_0008);

    // Release: full queue pops and refills each cycle.
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("stream_head", out_pcp4, 32'h0040_000C + 32'(4 * k));
      chk("stream_count", 32'(count), 32'd4);
    end

    // Drop to three entries, then redirect.
    fetch_en = 1'b0;
    tick();
    chk("pre_redir_count", 32'(count), 32'd3);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_1003;
    fetch_en    = 1'b1;
    #1;
    chk("redir_head_stable", out_pcp4, 32'h0040_001C);
    chk("redir_valid_stable", 32'(out_valid), 32'd1);
    tick();
    redirect = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_addr", imem_addr, 32'h0000_1000);
    chk("flush_valid", 32'(out_valid), 32'd0);
    tick();
    chk("target_pcp4", out_pcp4, 32'h0000_1004);
    chk("target_instr", out_instr, 32'hA5A5_B5A5);

    // Back-to-back redirects: last one wins.
    redirect    = 1'b1;
    redirect_pc = 32'h0000_2000;
    tick();
    redirect_pc = 32'h0000_3008;
    tick();
    redirect = 1'b0;
    chk("b2b_addr", imem_addr, 32'h0000_3008);
    chk("b2b_count", 32'(count), 32'd0);
    tick();
    chk("b2b_pcp4", out_pcp4, 32'h0000_300C);

    // fetch_en low with two queued: drain, then PC holds.
    out_ready = 1'b0;
    tick();
    chk("two_queued", 32'(count), 32'd2);
    fetch_en  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("drain_pcp4", out_pcp4, 32'h0000_3010);
    chk("drain_count", 32'(count), 32'd1);
    tick();
    chk("drained_valid", 32'(out_valid), 32'd0);
    chk("held_pc", imem_addr, 32'h0000_3010);
    tick();
    chk("held_pc2", imem_addr, 32'h0000_3010);
    fetch_en = 1'b1;
    tick();
    chk("resume_pcp4", out_pcp4, 32'h0000_3014);

    // Asynchronous reset mid-stream with three entries queued.
    out_ready = 1'b0;
    tick();
    tick();
    chk("pre_rst_count", 32'(count), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_pcp4", out_pcp4, 32'h0);
    chk("arst_instr", out_instr, 32'h0);
    chk("arst_addr", imem_addr, 32'h0040_0000);
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("restart_pcp4", out_pcp4, 32'h0040_0004);
    tick();
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Parametrised instruction-fetch stage that replaces the bare PC register and PC+4/branch/jump mux of the 5-stage pipeline with a decoupled prefetch buffer.
- Owns the PC, reads instruction memory combinationally, and pushes {PC+4, instruction} pairs into a DEPTH-entry FIFO.
- Decode consumes entries through a valid/ready handshake.
- Branch/jump redirects from EX/ID flush the queue and restart fetch at the target.

Parameters:
- ADDR_W, 32, width of PC and instruction-memory address.
- INSTR_W, 32, instruction width.
- DEPTH, 4, queue entries; power of two, >= 2.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  pipeline clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_en  in  1  permits new fetches; when low, the queue only drains.
- imem_addr  out  ADDR_W  current PC, driven to instruction memory.
- imem_data  in  INSTR_W  instruction at imem_addr, valid in the same cycle.
- redirect  in  1  branch/jump taken; flush and reload PC.
- redirect_pc  in  ADDR_W  target; bits [1:0] are ignored and treated as 0.
- out_valid  out  1  head entry available to decode.
- out_ready  in  1  decode accepts head (deasserted = stall).
- out_instr  out  INSTR_W  head instruction.
- out_pcp4  out  ADDR_W  head PC+4.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - pc = RESET_PC with [1:0] cleared; rd/wr pointers = 0; count = 0.
  - out_valid = 0; out_instr = 0; out_pcp4 = 0.
- imem_addr = pc, combinational.
- pop = out_valid & out_ready.
- push = fetch_en & ~redirect & (count < DEPTH | pop).
  - Push writes {pc+4, imem_data} at wr_ptr; pc <= pc+4, wrapping modulo 2^ADDR_W.
- out_valid = (count != 0). out_instr/out_pcp4 = head entry when valid, 0 when empty. Never combinationally dependent on redirect.
- Latency: a fetch at cycle N is visible at out_valid in cycle N+1. With out_ready held high, throughput is 1 instruction per cycle.
- Simultaneous push and pop:
  - Legal at count == DEPTH: the entry frees and refills in the same cycle.
  - count is unchanged.
- Full (count == DEPTH) without pop: no push, pc holds, imem_data is ignored.
- Empty with fetch_en low: out_valid = 0, pc holds.
- Redirect has priority over push:
  - Cycle of redirect: a pop in that cycle is a legal handoff of the older head.
  - Next edge: all entries dropped (count = 0, rd_ptr = wr_ptr); pc <= {redirect_pc[ADDR_W-1:2], 2'b00}; no push.
  - First target instruction is fetched in the following cycle and appears at out_valid two cycles after redirect is sampled.
- Back-to-back redirects: the last one wins; each flushes.
- Pointers wrap modulo DEPTH; count is never allowed to exceed DEPTH.
- Reset mid-operation: immediate return to reset values; in-flight entries are lost.

Decomposition:
- Shared package fetch_pkg: the entry struct typedef {pcp4, instr}; constant for PC increment (4); alignment mask for [1:0].
- One sub-module: fetch_fifo, a parametrised synchronous FIFO with flush, push/pop, count, and head read. The top holds the PC, push/redirect logic and the imem interface.

Test Plan:
- Reset with RESET_PC=0x00400000, fetch_en=1, out_ready=1, imem returns addr^0xA5A5A5A5 -> out_pcp4 sequence 0x00400004, 0x00400008, ... one per cycle; out_valid rises 1 cycle after rst_n deassert.
- out_ready=0 for 10 cycles, DEPTH=4 -> count saturates at 4 after 4 cycles, imem_addr frozen at 0x00400010; on release, 4 queued entries drain in order with no gap or duplicate.
- Redirect to 0x00001003 while count=3 -> next cycle count=0 and imem_addr=0x00001000; first new out_pcp4=0x00001004 appears 2 cycles after redirect; no stale entry is ever seen.
- Full queue plus simultaneous pop and push -> count stays 4; the popped entry is the oldest; the new entry lands at the tail.
- fetch_en=0 with 2 entries queued -> both drain, then out_valid=0 and pc holds; re-enable resumes at the held pc.
- rst_n asserted mid-stream with count=3 -> outputs are 0 and count=0 immediately (asynchronously); fetch restarts at RESET_PC.
